axis_sync_fifo: RTL and testbench
=================================

Name: axis_sync_fifo

Overview:
- Single-clock, first-word-fall-through AXI-Stream FIFO. Stores an opaque packed word of WIDTH bits.
- Wrappers flatten tdata/tkeep/tuser/tlast into that word before entry and unpack it after exit.
- Used as a buffer or as a pipeline stage between stream blocks.
- Reports free space and fill level.

Parameters:
- WIDTH, 32, bit width of the packed payload word; legal range 1 or more.
- SIZE, 1, log2 of depth; depth = 2**SIZE words; legal range 0..15. SIZE=0 selects pass-through mode.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush; same effect as reset on FIFO state
- i_tdata  input  WIDTH  write data
- i_tvalid  input  1  write valid
- i_tready  output  1  FIFO can accept a word
- o_tdata  output  WIDTH  read data, head of FIFO
- o_tvalid  output  1  FIFO holds at least one word
- o_tready  input  1  downstream accepts head word
- space  output  16  free entries, zero-extended
- occupied  output  16  stored entries, zero-extended

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high (ports clk and reset).
- Push occurs when i_tvalid && i_tready. Pop occurs when o_tvalid && o_tready. Both are sampled at the rising clk edge.
- i_tready = (occupied < 2**SIZE). It is a registered or state-derived signal with no combinational path from o_tready, so a full FIFO does not accept a word even when a pop happens in the same cycle.
- o_tvalid = (occupied > 0). It has no combinational path from i_tvalid.
- Latency: a word pushed at edge N appears on o_tdata with o_tvalid=1 after edge N, at the earliest from cycle N+1. This holds even when the FIFO was empty.
- Ordering: strict FIFO order; no loss or duplication.
- o_tdata must hold stable while o_tvalid=1 and o_tready=0. o_tdata is don't-care while o_tvalid=0 and is not reset.
- Simultaneous push and pop (0 < occupied < depth): occupied and space unchanged, data order preserved.
- Push and pop with occupied=0: only the push takes effect, since o_tvalid=0.
- space + occupied = 2**SIZE at all times when SIZE >= 1. Both counters update on the edge after the handshake.
- Read and write pointers wrap modulo 2**SIZE; full and empty must be distinguished correctly across wrap, for example with an explicit count or an extra pointer bit.
- On reset or clear at edge N, from cycle N+1:
  - occupied=0, space=2**SIZE
  - o_tvalid=0, i_tready=1
  - any stored data is discarded
- reset and clear take priority over a push or pop in the same cycle; the handshake in that cycle is dropped.
- Reset or clear while full or mid-stream behaves identically.
- SIZE=0: purely combinational wire. o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready, space=0, occupied=0; reset and clear are ignored.
- Storage may be registers, distributed RAM or block RAM. The external behaviour above is identical for every SIZE >= 1.

Test Plan:
- Reset then idle, SIZE=4 -> occupied=0, space=16, o_tvalid=0, i_tready=1.
- SIZE=4, push 0x1..0x10 with o_tready=0 -> after the 16th push: i_tready=0, occupied=16, space=0. A 17th push attempt is not accepted. Then hold o_tready=1 -> outputs 0x1..0x10 in order, final occupied=0.
- Empty FIFO, single push of 0xA5 at edge N -> o_tvalid=0 during cycle N, o_tvalid=1 and o_tdata=0xA5 in cycle N+1.
- SIZE=2, continuous push/pop with random valid/ready over 1000 words -> output order matches the input sequence, no drops, pointers wrap, and space+occupied=4 every cycle.
- Fill to occupied=3, then assert clear together with push and pop -> next cycle occupied=0, space=depth, o_tvalid=0; stale data never appears on the output.
- SIZE=0 -> output signals follow inputs in the same cycle; space=occupied=0.

Source files
------------

// File: rtl/axis_sync_fifo.sv
// ---------------------------------------------------------------------------
// axis_sync_fifo
//   Single-clock, first-word-fall-through stream FIFO that holds an opaque
//   packed word. Wrappers pack tdata/tkeep/tuser/tlast into i_tdata and
//   unpack them from o_tdata.
//
// Parameters
//   WIDTH : payload word width in bits (>= 1)
//   SIZE  : log2 of the depth (0..15). SIZE = 0 turns the block into a
//           straight wire with no storage.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   clear     synchronous flush, same effect on FIFO state as reset
//   i_tdata   write word
//   i_tvalid  write valid
//   i_tready  FIFO can accept a word (state-derived only)
//   o_tdata   head-of-FIFO word (not reset, undefined while o_tvalid = 0)
//   o_tvalid  FIFO holds at least one word (state-derived only)
//   o_tready  downstream accepts the head word
//   space     free entries, zero-extended to 16 bits
//   occupied  stored entries, zero-extended to 16 bits
// ---------------------------------------------------------------------------
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      space,
  output logic [15:0]      occupied
);

  generate
    if (SIZE == 0) begin : g_pass
      // No storage: the stage collapses to wires, so clk/reset/clear have
      // nothing to act on.
      assign o_tdata  = i_tdata;
      assign o_tvalid = i_tvalid;
      assign i_tready = o_tready;
      assign space    = 16'd0;
      assign occupied = 16'd0;
    end else begin : g_fifo
      localparam int DEPTH = 1 << SIZE;

      logic [WIDTH-1:0] mem [DEPTH];
      logic [SIZE-1:0]  wr_ptr_reg;
      logic [SIZE-1:0]  rd_ptr_reg;
      // One bit wider than the pointers so "full" (count = DEPTH) and
      // "empty" (count = 0) stay distinct after the pointers wrap.
      logic [SIZE:0]    count_reg;
      logic             flush;
      logic             push;
      logic             pop;

      assign flush = reset | clear;

      // Both handshake readies come straight from the stored count, so a
      // full FIFO refuses a word even when the head is popped in that cycle.
      assign i_tready = ~count_reg[SIZE];
      assign o_tvalid = (count_reg != '0);

      assign push = i_tvalid & i_tready;
      assign pop  = o_tvalid & o_tready;

      // Asynchronous read of the head slot gives first-word-fall-through:
      // a word written at one edge is visible right after that edge. The
      // head slot is never overwritten while it holds live data because a
      // write can only land on it when the FIFO is empty.
      assign o_tdata = mem[rd_ptr_reg];

      // Storage has no reset, which keeps it mappable onto RAM primitives.
      always_ff @(posedge clk) begin
        if (push && !flush) begin
          mem[wr_ptr_reg] <= i_tdata;
        end
      end

      always_ff @(posedge clk) begin
        if (flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign occupied = 16'(count_reg);
      assign space    = 16'(DEPTH) - 16'(count_reg);
    end
  endgenerate

endmodule

// File: tb/tb_axis_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_sync_fifo
//   Self-checking bench for axis_sync_fifo. Three instances are exercised:
//   SIZE=4 (depth 16), SIZE=2 (depth 4) and SIZE=0 (pass-through). Each
//   buffered instance is mirrored by a queue holding the words the FIFO
//   should contain; expected flags and counts follow from the queue length.
// ---------------------------------------------------------------------------
module tb_axis_sync_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  // SIZE = 4, WIDTH = 32
  logic        clear4 = 1'b0, i_tvalid4 = 1'b0, o_tready4 = 1'b0;
  logic [31:0] i_tdata4 = '0;
  logic        i_tready4, o_tvalid4;
  logic [31:0] o_tdata4;
  logic [15:0] space4, occupied4;

  // SIZE = 2, WIDTH = 16
  logic        clear2 = 1'b0, i_tvalid2 = 1'b0, o_tready2 = 1'b0;
  logic [15:0] i_tdata2 = '0;
  logic        i_tready2, o_tvalid2;
  logic [15:0] o_tdata2;
  logic [15:0] space2, occupied2;

  // SIZE = 0, WIDTH = 8
  logic        clear0 = 1'b0, i_tvalid0 = 1'b0, o_tready0 = 1'b0;
  logic [7:0]  i_tdata0 = '0;
  logic        i_tready0, o_tvalid0;
  logic [7:0]  o_tdata0;
  logic [15:0] space0, occupied0;

  axis_sync_fifo #(.WIDTH(32), .SIZE(4)) u_dut4 (
    .clk(clk), .reset(reset), .clear(clear4),
    .i_tdata(i_tdata4), .i_tvalid(i_tvalid4), .i_tready(i_tready4),
    .o_tdata(o_tdata4), .o_tvalid(o_tvalid4), .o_tready(o_tready4),
    .space(space4), .occupied(occupied4)
  );

  axis_sync_fifo #(.WIDTH(16), .SIZE(2)) u_dut2 (
    .clk(clk), .reset(reset), .clear(clear2),
    .i_tdata(i_tdata2), .i_tvalid(i_tvalid2), .i_tready(i_tready2),
    .o_tdata(o_tdata2), .o_tvalid(o_tvalid2), .o_tready(o_tready2),
    .space(space2), .occupied(occupied2)
  );

  axis_sync_fifo #(.WIDTH(8), .SIZE(0)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear0),
    .i_tdata(i_tdata0), .i_tvalid(i_tvalid0), .i_tready(i_tready0),
    .o_tdata(o_tdata0), .o_tvalid(o_tvalid0), .o_tready(o_tready0),
    .space(space0), .occupied(occupied0)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pops2       = 0;

  logic [31:0] q4 [$];
  logic [15:0] q2 [$];

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle on the depth-16 instance: drive, check mid-cycle against
  // the queue, then retire the handshake into the queue at the edge.
  task automatic cycle4(input logic clr, input logic vld,
                        input logic [31:0] d, input logic rdy);
    int  n;
    bit  do_push, do_pop;
    clear4 = clr; i_tvalid4 = vld; i_tdata4 = d; o_tready4 = rdy;
    #4;
    n = q4.size();
    check_value("dut4.occupied", 32'(occupied4), 32'(n));
    check_value("dut4.space", 32'(space4), 32'(16 - n));
    check_value("dut4.o_tvalid", 32'(o_tvalid4), 32'(n > 0));
    check_value("dut4.i_tready", 32'(i_tready4), 32'(n < 16));
    if (n > 0) check_value("dut4.o_tdata", o_tdata4, q4[0]);
    do_push = vld && (n < 16);
    do_pop  = rdy && (n > 0);
    if (reset || clr) begin
      q4.delete();
      $display("dut4 flush");
    end else begin
      if (do_pop) begin
        $display("dut4 pop  0x%08h", q4[0]);
        void'(q4.pop_front());
      end
      if (do_push) begin
        q4.push_back(d);
        $display("dut4 push 0x%08h", d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cycle2(input logic clr, input logic vld,
                        input logic [15:0] d, input logic rdy);
    int  n;
    bit  do_push, do_pop;
    clear2 = clr; i_tvalid2 = vld; i_tdata2 = d; o_tready2 = rdy;
    #4;
    n = q2.size();
    check_value("dut2.occupied", 32'(occupied2), 32'(n));
    check_value("dut2.space", 32'(space2), 32'(4 - n));
    check_value("dut2.o_tvalid", 32'(o_tvalid2), 32'(n > 0));
    check_value("dut2.i_tready", 32'(i_tready2), 32'(n < 4));
    if (n > 0) check_value("dut2.o_tdata", 32'(o_tdata2), 32'(q2[0]));
    do_push = vld && (n < 4);
    do_pop  = rdy && (n > 0);
    if (reset || clr) begin
      q2.delete();
      $display("dut2 flush");
    end else begin
      if (do_pop) begin
        $display("dut2 pop  0x%04h", q2[0]);
        void'(q2.pop_front());
        pops2++;
      end
      if (do_push) q2.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    logic       v0, r0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, idle.
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);

    // Fill to full, then try a 17th push both alone and with a pop.
    for (int i = 1; i <= 16; i++) cycle4(1'b0, 1'b1, 32'(i), 1'b0);
    cycle4(1'b0, 1'b1, 32'h11, 1'b0);
    cycle4(1'b0, 1'b1, 32'h12, 1'b1);
    for (int k = 0; k < 40 && q4.size() > 0; k++) cycle4(1'b0, 1'b0, 32'h0, 1'b1);
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);

    // Single word into an empty FIFO: invisible in its push cycle,
    // at the head one cycle later.
    cycle4(1'b0, 1'b1, 32'hA5, 1'b0);
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);
    check_value("dut4.latency_data", o_tdata4, 32'hA5);
    cycle4(1'b0, 1'b0, 32'h0, 1'b1);
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset mid-stream beats a simultaneous push and pop.
    for (int i = 0; i < 5; i++) cycle4(1'b0, 1'b1, $urandom, 1'b0);
    reset = 1'b1;
    q2.delete();
    cycle4(1'b0, 1'b1, 32'h77, 1'b1);
    reset = 1'b0;
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);
    cycle4(1'b0, 1'b1, 32'hC0DE, 1'b0);
    cycle4(1'b0, 1'b0, 32'h0, 1'b1);
    cycle4(1'b0, 1'b0, 32'h0, 1'b0);

    // Clear with push and pop at occupied = 3; no stale word may surface.
    for (int i = 0; i < 3; i++) cycle2(1'b0, 1'b1, 16'(32'h1000 + i), 1'b0);
    cycle2(1'b1, 1'b1, 16'h5555, 1'b1);
    cycle2(1'b0, 1'b1, 16'hBEEF, 1'b0);
    cycle2(1'b0, 1'b0, 16'h0, 1'b0);
    check_value("dut2.after_clear_head", 32'(o_tdata2), 32'hBEEF);
    cycle2(1'b0, 1'b0, 16'h0, 1'b1);
    cycle2(1'b0, 1'b0, 16'h0, 1'b0);

    // Random traffic through depth 4 until 1000 words have left.
    pops2 = 0;
    for (int c = 0; c < 20000 && pops2 < 1000; c++) begin
      cycle2(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom),
             1'($urandom_range(0, 3) != 0));
    end
    check_value("dut2.random_words_out", 32'(pops2 >= 1000), 32'd1);

    // Pass-through instance: outputs follow inputs within the cycle.
    for (int i = 0; i < 20; i++) begin
      d0 = 8'($urandom);
      v0 = 1'($urandom);
      r0 = 1'($urandom);
      i_tdata0 = d0; i_tvalid0 = v0; o_tready0 = r0; clear0 = 1'($urandom);
      #1;
      check_value("dut0.o_tdata", 32'(o_tdata0), 32'(d0));
      check_value("dut0.o_tvalid", 32'(o_tvalid0), 32'(v0));
      check_value("dut0.i_tready", 32'(i_tready0), 32'(r0));
      check_value("dut0.space", 32'(space0), 32'd0);
      check_value("dut0.occupied", 32'(occupied0), 32'd0);
      $display("dut0 pass 0x%02h valid=%0d ready=%0d", d0, v0, r0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
